// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with a first-word-fall-through byte FIFO.
// Flags framing errors and overruns as single-cycle pulses.
module uart_rx_fifo #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8,
    localparam int CW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          uart_rx,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [7:0]    rd_data,
    output logic [CW-1:0] fifo_count,
    output logic          frame_err,
    output logic          overrun
);

    localparam int CPB  = CLK_FREQ / BAUD;
    localparam int HALF = CPB / 2;
    localparam int TW   = $clog2(CPB);
    localparam int PW   = CW - 1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t  state_q, state_d;
    logic    sync1, rxs, prev;
    logic [TW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shift;
    logic    cnt_clr, idx_clr, shift_en;
    logic    push_req, ferr_d;
    logic    push, pop;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wptr, rptr;

    // prev starts high so a line held low at reset release looks like a start edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
            prev  <= 1'b1;
        end else begin
            sync1 <= uart_rx;
            rxs   <= sync1;
            prev  <= rxs;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            shift   <= '0;
        end else begin
            state_q <= state_d;
            cnt     <= cnt_clr ? '0 : cnt + 1'b1;
            if (shift_en) shift[idx] <= rxs;
            if (idx_clr) idx <= '0;
            else if (shift_en) idx <= idx + 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_clr  = 1'b0;
        idx_clr  = 1'b0;
        shift_en = 1'b0;
        push_req = 1'b0;
        ferr_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_clr = 1'b1;
                if (!rxs && prev) state_d = START;
            end
            START: begin
                if (cnt == TW'(HALF - 1)) begin
                    cnt_clr = 1'b1;
                    idx_clr = 1'b1;
                    state_d = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == TW'(CPB - 1)) begin
                    cnt_clr  = 1'b1;
                    shift_en = 1'b1;
                    if (idx == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                // leave at mid stop bit so a back-to-back start edge is caught
                if (cnt == TW'(CPB - 1)) begin
                    cnt_clr  = 1'b1;
                    state_d  = IDLE;
                    push_req = rxs;
                    ferr_d   = !rxs;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rd_valid = (fifo_count != '0);
    assign pop      = rd_valid && rd_ready;
    assign push     = push_req &&
                      ((fifo_count < CW'(FIFO_DEPTH)) || pop);
    assign rd_data  = rd_valid ? mem[rptr] : 8'h00;

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= shift;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_count <= '0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= ferr_d;
            overrun   <= push_req && !push;
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            if (push && !pop)      fifo_count <= fifo_count + 1'b1;
            else if (pop && !push) fifo_count <= fifo_count - 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: directed frames in,
// monitor pops expected bytes and counts flag pulses.
module tb_uart_rx_fifo;

    localparam int CPB = 434;
    localparam int CW  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          uart_rx;
    logic          rd_valid;
    logic          rd_ready;
    logic [7:0]    rd_data;
    logic [CW-1:0] fifo_count;
    logic          frame_err;
    logic          overrun;

    int vectors = 0;
    int errors  = 0;
    int seen_ferr = 0;
    int seen_ovr  = 0;
    int lat;
    logic [7:0] q[$];

    uart_rx_fifo #(
        .CLK_FREQ(50_000_000),
        .BAUD(115200),
        .FIFO_DEPTH(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .uart_rx(uart_rx),
        .rd_valid(rd_valid),
        .rd_ready(rd_ready),
        .rd_data(rd_data),
        .fifo_count(fifo_count),
        .frame_err(frame_err),
        .overrun(overrun)
    );

    always #10 clk = ~clk;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic line_bit(input logic b);
        uart_rx = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        line_bit(1'b0);
        for (int i = 0; i < 8; i++) line_bit(d[i]);
        line_bit(stop);
        uart_rx = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (q.size() != 0 && t < 2000) begin
            @(posedge clk);
            #1;
            t++;
        end
        check(name, q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (frame_err) seen_ferr++;
            if (overrun) seen_ovr++;
            if (rd_valid && rd_ready) begin
                vectors++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL pop_unexpected: got %0h expected none", rd_data);
                end else begin
                    logic [7:0] e;
                    e = q.pop_front();
                    if (rd_data !== e) begin
                        errors++;
                        $display("FAIL pop_data: got %0h expected %0h", rd_data, e);
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        uart_rx = 1'b1;
        rd_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", rd_valid, 0);
        check("rst_data", rd_data, 0);
        check("rst_count", fifo_count, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_ovr", overrun, 0);
        rst = 1'b0;
        idle(20);

        // 1: single frame and its latency
        q.push_back(8'h43);
        fork
            send_byte(8'h43, 1'b1);
            begin
                lat = 0;
                while (!rd_valid && lat < 6000) begin
                    @(posedge clk);
                    #1;
                    lat++;
                end
            end
        join
        check("t1_latency", lat, 2 + CPB / 2 + 9 * CPB + 1);
        idle(5);
        check("t1_count", fifo_count, 0);
        check("t1_flags", seen_ferr + seen_ovr, 0);

        // 2: two buffered frames
        rd_ready = 1'b0;
        q.push_back(8'h50);
        send_byte(8'h50, 1'b1);
        q.push_back(8'h55);
        send_byte(8'h55, 1'b1);
        idle(3);
        check("t2_count", fifo_count, 2);
        check("t2_head", rd_data, 8'h50);
        rd_ready = 1'b1;
        idle(4);
        check("t2_valid", rd_valid, 0);
        check("t2_data", rd_data, 0);

        // 3: bad stop bit then a clean frame
        send_byte(8'hA5, 1'b0);
        idle(CPB);
        check("t3_ferr", seen_ferr, 1);
        check("t3_count", fifo_count, 0);
        q.push_back(8'h5A);
        send_byte(8'h5A, 1'b1);
        idle(10);
        check("t3_drain", q.size(), 0);

        // 4: short glitch
        uart_rx = 1'b0;
        idle(100);
        uart_rx = 1'b1;
        idle(2 * CPB);
        check("t4_ferr", seen_ferr, 1);
        check("t4_count", fifo_count, 0);

        // 5: fill, overrun, drain with pointer wrap
        rd_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            q.push_back(8'(i));
            send_byte(8'(i), 1'b1);
        end
        send_byte(8'h09, 1'b1);
        idle(5);
        check("t5_count", fifo_count, 8);
        check("t5_ovr", seen_ovr, 1);
        check("t5_head", rd_data, 8'h01);
        rd_ready = 1'b1;
        drain("t5_drain");
        idle(3);
        check("t5_valid", rd_valid, 0);

        // 6: reset mid-frame flushes everything
        rd_ready = 1'b0;
        q.push_back(8'h77);
        send_byte(8'h77, 1'b1);
        idle(3);
        check("t6_pre_count", fifo_count, 1);
        line_bit(1'b0);
        for (int i = 0; i < 4; i++) line_bit(i[0]);
        uart_rx = 1'b1;
        idle(CPB / 2);
        rst = 1'b1;
        #2;
        check("t6_rst_valid", rd_valid, 0);
        check("t6_rst_count", fifo_count, 0);
        check("t6_rst_data", rd_data, 0);
        check("t6_rst_flags", {frame_err, overrun}, 0);
        q.delete();
        idle(3);
        rst = 1'b0;
        rd_ready = 1'b1;
        idle(20);
        q.push_back(8'h3C);
        send_byte(8'h3C, 1'b1);
        drain("t6_drain");
        check("final_ferr", seen_ferr, 1);
        check("final_ovr", seen_ovr, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
